// File: rtl/grid_cell_editor.sv
// Centre-button cell toggle (read-modify-write) into the shared Game-of-Life grid RAM.
// Define GRID_EDIT_CLEAR_EN to add the clr-driven sweep that zeroes every cell.
module grid_cell_editor #(
    parameter int GRID_W = 80,
    parameter int GRID_H = 60,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btnC,
    input  logic              clr,
    input  logic [6:0]        cursorX,
    input  logic [5:0]        cursorY,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_wdata,
    input  logic              mem_rdata,
    output logic              edit_busy,
    output logic              edit_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4,
        CLR   = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        btn_sync_q, btn_sync_d;
    logic              btn_prev_q, btn_prev_d;
    logic              btn_edge;
    logic              clr_edge;
    logic              clr_active;
    logic [ADDR_W-1:0] cursor_addr;
    logic [ADDR_W-1:0] x_ext, y_ext;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_wdata_q, mem_wdata_d;
    logic              edit_busy_q, edit_busy_d;
    logic              edit_done_q, edit_done_d;

    assign x_ext = ADDR_W'(cursorX);
    assign y_ext = ADDR_W'(cursorY);

    // Row stride of 80 is 64+16, so the default geometry needs no multiplier.
    generate
        if (GRID_W == 80) begin : g_addr_shift
            assign cursor_addr = (y_ext << 6) + (y_ext << 4) + x_ext;
        end else begin : g_addr_mult
            assign cursor_addr = (y_ext * ADDR_W'(GRID_W)) + x_ext;
        end
    endgenerate

    always_comb begin
        btn_sync_d = {btn_sync_q[1:0], btnC};
        btn_prev_d = btn_sync_q[2];
    end

    assign btn_edge = btn_sync_q[2] & ~btn_prev_q;

`ifdef GRID_EDIT_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);

    logic [2:0] clr_sync_q, clr_sync_d;
    logic       clr_prev_q, clr_prev_d;
    logic       clr_flag_q, clr_flag_d;

    always_comb begin
        clr_sync_d = {clr_sync_q[1:0], clr};
        clr_prev_d = clr_sync_q[2];
        clr_flag_d = clr_flag_q;
        if (state_q == IDLE) begin
            clr_flag_d = clr_edge;
        end
    end

    assign clr_edge   = clr_sync_q[2] & ~clr_prev_q;
    assign clr_active = clr_flag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_sync_q <= 3'b000;
            clr_prev_q <= 1'b0;
            clr_flag_q <= 1'b0;
        end else begin
            clr_sync_q <= clr_sync_d;
            clr_prev_q <= clr_prev_d;
            clr_flag_q <= clr_flag_d;
        end
    end
`else
    logic [31:0] unused_cfg;

    assign unused_cfg = {31'(GRID_H), clr};
    assign clr_edge   = 1'b0;
    assign clr_active = 1'b0;
`endif

    // Next state and address; only IDLE looks at edges, so presses while busy are dropped.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (clr_edge) begin
                    state_d    = REQ;
                    mem_addr_d = '0;
                end else if (btn_edge) begin
                    state_d    = REQ;
                    mem_addr_d = cursor_addr;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = clr_active ? CLR : READ;
                end
            end
            READ:  state_d = WAIT;
            WAIT:  state_d = WRITE;
            WRITE: state_d = DONE;
`ifdef GRID_EDIT_CLEAR_EN
            CLR: begin
                if (mem_addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    mem_addr_d = mem_addr_q + 1'b1;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with it.
    always_comb begin
        mem_req_d   = (state_d == REQ) || (state_d == READ) || (state_d == WAIT) ||
                      (state_d == WRITE) || (state_d == CLR);
        mem_we_d    = (state_d == WRITE) || (state_d == CLR);
        mem_wdata_d = 1'b0;
        if (state_q == WAIT) begin
            mem_wdata_d = ~mem_rdata;
        end
        edit_busy_d = (state_d != IDLE);
        edit_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            btn_sync_q  <= 3'b000;
            btn_prev_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 1'b0;
            edit_busy_q <= 1'b0;
            edit_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_sync_q  <= btn_sync_d;
            btn_prev_q  <= btn_prev_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            edit_busy_q <= edit_busy_d;
            edit_done_q <= edit_done_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign edit_busy = edit_busy_q;
    assign edit_done = edit_done_q;

endmodule

// File: tb/tb_grid_cell_editor.sv
// Bench for grid_cell_editor: grid RAM model with arbiter grant, cell-array reference model.
module tb_grid_cell_editor;

    localparam int W = 80;
    localparam int H = 60;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btnC = 1'b0;
    logic        clr = 1'b0;
    logic [6:0]  cursorX = 7'd0;
    logic [5:0]  cursorY = 6'd0;
    logic        mem_gnt = 1'b0;
    logic        mem_rdata = 1'b0;
    logic        mem_req;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic        mem_wdata;
    logic        edit_busy;
    logic        edit_done;

    grid_cell_editor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btnC      (btnC),
        .clr       (clr),
        .cursorX   (cursorX),
        .cursorY   (cursorY),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .edit_busy (edit_busy),
        .edit_done (edit_done)
    );

    always #5 clk = ~clk;

    bit ram [0:N-1];
    bit model [0:N-1];
    bit preload_req = 1'b0;
    int wr_count = 0;
    int done_count = 0;
    int last_addr = -1;
    int last_data = -1;
    int oob_count = 0;
    int clr_next = 0;
    int clr_bad = 0;
    int errors = 0;
    int checks = 0;

    // Grid RAM: writes only while granted, registered read data.
    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < N; i++) ram[i] <= 1'b1;
            clr_next <= 0;
            clr_bad  <= 0;
        end else if (mem_req && mem_gnt && mem_we) begin
            if (int'(mem_addr) < N) ram[mem_addr] <= mem_wdata;
            else oob_count <= oob_count + 1;
            wr_count  <= wr_count + 1;
            last_addr <= int'(mem_addr);
            last_data <= int'(mem_wdata);
            if (int'(mem_addr) == clr_next && !mem_wdata) clr_next <= clr_next + 1;
            else clr_bad <= clr_bad + 1;
        end
        if (!mem_we && int'(mem_addr) < N) mem_rdata <= ram[mem_addr];
    end

    always @(negedge clk) begin
        if (edit_done) done_count <= done_count + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One press; grant withheld for 'stall' cycles of REQ; optional second press while busy.
    task automatic do_toggle(input int x, input int y, input int stall, input bit extra_press);
        int a, w0, d0, done_n;
        bit old, req_low;
        a = y * W + x;
        old = model[a];
        cursorX = 7'(x);
        cursorY = 6'(y);
        mem_gnt = (stall == 0);
        @(negedge clk);
        w0 = wr_count;
        d0 = done_count;
        btnC = 1'b1;
        @(posedge clk);
        #1 btnC = 1'b0;
        done_n = 0;
        req_low = 1'b0;
        for (int n = 1; n <= 40 && done_n == 0; n++) begin
            @(posedge clk);
            #1;
            if (n == 3) check("busy_at_req", int'(edit_busy), 1);
            if (n >= 3 && n <= 3 + stall && !mem_req) req_low = 1'b1;
            if (n == 3 + stall) mem_gnt = 1'b1;
            if (n >= 4) begin
                cursorX = 7'($urandom_range(0, W - 1));
                cursorY = 6'($urandom_range(0, H - 1));
            end
            if (extra_press && n == 4) btnC = 1'b1;
            if (extra_press && n == 5) btnC = 1'b0;
            if (edit_done) done_n = n;
        end
        check("done_latency", done_n, 7 + stall);
        if (stall > 0) check("req_held_in_stall", int'(req_low), 0);
        repeat (12) @(posedge clk);
        #1;
        model[a] = !old;
        check("write_count", wr_count - w0, 1);
        check("write_addr", last_addr, a);
        check("write_data", last_data, int'(model[a]));
        check("done_pulses", done_count - d0, 1);
        check("busy_after", int'(edit_busy), 0);
        check("ram_cell", int'(ram[a]), int'(model[a]));
        $display("toggle x=%0d y=%0d addr=%0d stall=%0d extra=%0d latency=%0d cell=%0d",
                 x, y, a, stall, extra_press, done_n, model[a]);
    endtask

    initial begin
        int a, w0, d0, done_n, mism;
        for (int i = 0; i < N; i++) model[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", int'(mem_req), 0);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_mem_wdata", int'(mem_wdata), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_busy", int'(edit_busy), 0);
        check("rst_done", int'(edit_done), 0);
        $display("reset state checked");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_toggle(10, 5, 0, 1'b0);
        do_toggle(10, 5, 0, 1'b0);
        do_toggle(79, 59, 0, 1'b0);
        do_toggle(0, 0, 0, 1'b0);
        do_toggle(33, 17, 20, 1'b1);
        for (int r = 0; r < 5; r++) begin
            do_toggle(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)),
                      int'($urandom_range(0, 3)), 1'b0);
        end

        // Asynchronous reset while WRITE is on the bus.
        a = 22 * W + 41;
        cursorX = 7'd41;
        cursorY = 6'd22;
        mem_gnt = 1'b1;
        @(negedge clk);
        btnC = 1'b1;
        @(posedge clk);
        #1 btnC = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("we_in_write", int'(mem_we), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_we", int'(mem_we), 0);
        check("arst_busy", int'(edit_busy), 0);
        check("arst_mem_req", int'(mem_req), 0);
        check("arst_mem_addr", int'(mem_addr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst_cell", int'(ram[a]), int'(model[a]));
        $display("reset mid-write addr=%0d cell=%0d", a, ram[a]);
        do_toggle(41, 22, 0, 1'b0);

        // Preload all ones, then clr and btnC in the same cycle.
        for (int i = 0; i < N; i++) model[i] = 1'b1;
        @(negedge clk);
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
        a = 2 * W + 3;
        cursorX = 7'd3;
        cursorY = 6'd2;
        mem_gnt = 1'b1;
        @(negedge clk);
        w0 = wr_count;
        d0 = done_count;
        btnC = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        btnC = 1'b0;
        clr = 1'b0;
        done_n = 0;
        for (int n = 1; n <= 6000 && done_n == 0; n++) begin
            @(posedge clk);
            #1;
            if (edit_done) done_n = n;
        end
        repeat (12) @(posedge clk);
        #1;
        check("clr_done_pulses", done_count - d0, 1);
`ifdef GRID_EDIT_CLEAR_EN
        for (int i = 0; i < N; i++) model[i] = 1'b0;
        check("clr_latency", done_n, N + 4);
        check("clr_writes", wr_count - w0, N);
        check("clr_sequence_end", clr_next, N);
        check("clr_out_of_order", clr_bad, 0);
`else
        model[a] = 1'b0;
        check("noclr_latency", done_n, 7);
        check("noclr_writes", wr_count - w0, 1);
        check("noclr_addr", last_addr, a);
        check("noclr_data", last_data, 0);
`endif
        $display("clr+btnC latency=%0d writes=%0d", done_n, wr_count - w0);

        mism = 0;
        for (int i = 0; i < N; i++) if (ram[i] != model[i]) mism++;
        check("ram_image", mism, 0);
        check("out_of_range_writes", oob_count, 0);
        $display("grid image compared, differing cells=%0d", mism);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
